// File: rtl/ttt_pkg.sv
// Shared types, cell/result codes and move-decode helpers for the tic-tac-toe datapath.
package ttt_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_CHECK  = 3'd3,
        ST_RESULT = 3'd4
    } arb_state_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    function automatic logic onehot_valid(input logic [8:0] m);
        return (m != 9'd0) && ((m & (m - 9'd1)) == 9'd0);
    endfunction

    function automatic logic [3:0] onehot_to_idx(input logic [8:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (m[k]) idx = 4'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Purpose: free-running one-cycle frame tick every CLK_HZ/FPS clocks.
// Latency: first tick CLK_HZ/FPS cycles after reset release.
// Backpressure: none; the tick is never stalled.
module frame_tick_gen #(
    parameter int CLK_HZ = 10_000_000,
    parameter int FPS    = 60
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int PERIOD = (CLK_HZ / FPS > 0) ? CLK_HZ / FPS : 1;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(PERIOD - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/turn_arbiter.sv
// Purpose: turn arbitration, board commit, win-check handshake, result hold / clear / turn timeout.
// Latency: ack + board write 1 cycle after an accepted request, chk_start 1 cycle later.
// Backpressure: requests outside WAIT stay pending (no ack/nack); checker latency unbounded.
module turn_arbiter
    import ttt_pkg::*;
#(
    parameter int CLK_HZ              = 10_000_000,
    parameter int FPS                 = 60,
    parameter int RESULT_HOLD_FRAMES  = 180,
    parameter int TURN_TIMEOUT_FRAMES = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1_req,
    input  logic [8:0] p1_move,
    output logic       p1_ack,
    output logic       p1_nack,
    input  logic       p2_req,
    input  logic [8:0] p2_move,
    output logic       p2_ack,
    output logic       p2_nack,
    input  logic [8:0] occ,
    output logic       wr_en,
    output logic [3:0] wr_idx,
    output logic [1:0] wr_val,
    output logic       chk_start,
    input  logic       chk_done,
    input  logic [1:0] chk_result,
    output logic       player,
    output logic [1:0] winner,
    output logic       busy
);
    localparam int  HOLD_W    = (RESULT_HOLD_FRAMES > 1) ? $clog2(RESULT_HOLD_FRAMES + 1) : 1;
    localparam int  HOLD_LAST = (RESULT_HOLD_FRAMES > 0) ? RESULT_HOLD_FRAMES - 1 : 0;
    localparam int  TO_W      = (TURN_TIMEOUT_FRAMES > 1) ? $clog2(TURN_TIMEOUT_FRAMES + 1) : 1;
    localparam int  TO_LAST   = (TURN_TIMEOUT_FRAMES > 0) ? TURN_TIMEOUT_FRAMES - 1 : 0;
    localparam bit  TO_EN     = (TURN_TIMEOUT_FRAMES != 0);

    arb_state_t        state;
    logic [3:0]        clr_idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              p1_armed, p2_armed;
    logic              tick;

    logic              in_wait, p1_live, p2_live, cur_live, oth_live, cur_ok;
    logic              cur_ack, cur_nack, oth_nack;
    logic [8:0]        cur_move;

    frame_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .FPS    (FPS)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        in_wait  = (state == ST_WAIT);
        p1_live  = p1_req && p1_armed;
        p2_live  = p2_req && p2_armed;
        cur_live = player ? p2_live : p1_live;
        oth_live = player ? p1_live : p2_live;
        cur_move = player ? p2_move : p1_move;
        cur_ok   = onehot_valid(cur_move) && ((cur_move & occ) == 9'd0);
        cur_ack  = in_wait && cur_live && cur_ok;
        cur_nack = in_wait && cur_live && !cur_ok;
        oth_nack = in_wait && oth_live;
    end

    assign busy = rst || (state != ST_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_idx   <= 4'd0;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            p1_armed  <= 1'b0;
            p2_armed  <= 1'b0;
            p1_ack    <= 1'b0;
            p1_nack   <= 1'b0;
            p2_ack    <= 1'b0;
            p2_nack   <= 1'b0;
            wr_en     <= 1'b0;
            wr_idx    <= 4'd0;
            wr_val    <= CELL_EMPTY;
            chk_start <= 1'b0;
            player    <= 1'b0;
            winner    <= RES_NONE;
        end else begin
            p1_ack    <= cur_ack && !player;
            p2_ack    <= cur_ack && player;
            p1_nack   <= player ? oth_nack : cur_nack;
            p2_nack   <= player ? cur_nack : oth_nack;
            // Every live request in WAIT gets a response, so that is exactly when a port disarms.
            p1_armed  <= (in_wait && p1_live) ? 1'b0 : (p1_armed || !p1_req);
            p2_armed  <= (in_wait && p2_live) ? 1'b0 : (p2_armed || !p2_req);
            wr_en     <= 1'b0;
            chk_start <= 1'b0;

            case (state)
                ST_CLEAR: begin
                    if (clr_idx == 4'd9) begin
                        state  <= ST_WAIT;
                        player <= 1'b0;
                        winner <= RES_NONE;
                        to_cnt <= '0;
                    end else begin
                        wr_en   <= 1'b1;
                        wr_idx  <= clr_idx;
                        wr_val  <= CELL_EMPTY;
                        clr_idx <= clr_idx + 4'd1;
                    end
                end
                ST_WAIT: begin
                    if (cur_ack) begin
                        state  <= ST_COMMIT;
                        wr_en  <= 1'b1;
                        wr_idx <= onehot_to_idx(cur_move);
                        wr_val <= player ? CELL_P2 : CELL_P1;
                    end else if (TO_EN && tick) begin
                        if (to_cnt == TO_W'(TO_LAST)) begin
                            player <= !player;
                            to_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    chk_start <= 1'b1;
                    state     <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (chk_done) begin
                        if (chk_result == RES_NONE) begin
                            player <= !player;
                            state  <= ST_WAIT;
                            to_cnt <= '0;
                        end else begin
                            winner   <= chk_result;
                            state    <= ST_RESULT;
                            hold_cnt <= '0;
                        end
                    end
                end
                ST_RESULT: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
                            state    <= ST_CLEAR;
                            clr_idx  <= 4'd0;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_idx <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_arbiter.sv
// Directed bench for turn_arbiter: a main instance with the timeout disabled and a
// second idle instance with a 2-frame timeout; frame period is 4 clocks in both.
module tb_turn_arbiter;

    logic       clk;
    logic       rst;
    logic       p1_req, p2_req;
    logic [8:0] p1_move, p2_move;
    logic       p1_ack, p1_nack, p2_ack, p2_nack;
    logic [8:0] occ;
    logic       wr_en;
    logic [3:0] wr_idx;
    logic [1:0] wr_val;
    logic       chk_start, chk_done;
    logic [1:0] chk_result;
    logic       player, busy;
    logic [1:0] winner;

    logic       t_req;
    logic [8:0] t_move, t_occ;
    logic       t_chk_done;
    logic [1:0] t_chk_result;
    logic       t_p1_ack, t_p1_nack, t_p2_ack, t_p2_nack;
    logic       t_wr_en, t_chk_start, t_player, t_busy;
    logic [3:0] t_wr_idx;
    logic [1:0] t_wr_val, t_winner;

    int n_chk  = 0;
    int n_pass = 0;
    int cnt;

    turn_arbiter #(
        .CLK_HZ(40), .FPS(10), .RESULT_HOLD_FRAMES(180), .TURN_TIMEOUT_FRAMES(0)
    ) dut (
        .clk(clk), .rst(rst),
        .p1_req(p1_req), .p1_move(p1_move), .p1_ack(p1_ack), .p1_nack(p1_nack),
        .p2_req(p2_req), .p2_move(p2_move), .p2_ack(p2_ack), .p2_nack(p2_nack),
        .occ(occ), .wr_en(wr_en), .wr_idx(wr_idx), .wr_val(wr_val),
        .chk_start(chk_start), .chk_done(chk_done), .chk_result(chk_result),
        .player(player), .winner(winner), .busy(busy)
    );

    turn_arbiter #(
        .CLK_HZ(40), .FPS(10), .RESULT_HOLD_FRAMES(180), .TURN_TIMEOUT_FRAMES(2)
    ) dut_to (
        .clk(clk), .rst(rst),
        .p1_req(t_req), .p1_move(t_move), .p1_ack(t_p1_ack), .p1_nack(t_p1_nack),
        .p2_req(t_req), .p2_move(t_move), .p2_ack(t_p2_ack), .p2_nack(t_p2_nack),
        .occ(t_occ), .wr_en(t_wr_en), .wr_idx(t_wr_idx), .wr_val(t_wr_val),
        .chk_start(t_chk_start), .chk_done(t_chk_done), .chk_result(t_chk_result),
        .player(t_player), .winner(t_winner), .busy(t_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        p1_req = 1'b0; p2_req = 1'b0; p1_move = 9'd0; p2_move = 9'd0;
        occ = 9'd0; chk_done = 1'b0; chk_result = 2'b00;
        t_req = 1'b0; t_move = 9'd0; t_occ = 9'd0; t_chk_done = 1'b0; t_chk_result = 2'b00;

        // Reset, then the 9-cell clear sequence.
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_player", player, 0);
        chk("rst_winner", winner, 0);
        chk("rst_pulses", {p1_ack, p1_nack, p2_ack, p2_nack, chk_start}, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("clr_wr_en", wr_en, 1);
            chk("clr_wr_idx", wr_idx, i);
            chk("clr_wr_val", wr_val, 0);
            chk("clr_busy", busy, 1);
        end
        step();
        chk("wait_busy", busy, 0);
        chk("wait_wr_en", wr_en, 0);
        chk("wait_player", player, 0);
        chk("to_start_player", t_player, 0);

        // Timeout instance: ticks at r+4k, WAIT from r+10, flips after 2nd tick in WAIT.
        repeat (6) step();
        chk("to_before_flip", t_player, 0);
        step();
        chk("to_flip1", t_player, 1);
        repeat (7) step();
        chk("to_before_flip2", t_player, 1);
        step();
        chk("to_flip2", t_player, 0);
        chk("no_timeout_player", player, 0);

        // Valid P1 move to cell 4.
        p1_req = 1'b1; p1_move = 9'b000010000;
        step();
        chk("p1_ack", p1_ack, 1);
        chk("p1_no_nack", p1_nack, 0);
        chk("commit_wr_en", wr_en, 1);
        chk("commit_wr_idx", wr_idx, 4);
        chk("commit_wr_val", wr_val, 1);
        chk("commit_busy", busy, 1);
        p1_req = 1'b0; occ = 9'h010;
        step();
        chk("chk_start", chk_start, 1);
        chk("ack_one_cycle", p1_ack, 0);
        chk("wr_one_cycle", wr_en, 0);
        step();
        chk("chk_start_one_cycle", chk_start, 0);
        chk("check_busy", busy, 1);
        chk_done = 1'b1; chk_result = 2'b00;
        step();
        chk_done = 1'b0;
        chk("flip_to_p2", player, 1);
        chk("back_to_wait", busy, 0);

        // Valid P2 move to cell 0; checker answers in the first CHECK cycle.
        p2_req = 1'b1; p2_move = 9'b000000001;
        step();
        chk("p2_ack", p2_ack, 1);
        chk("p2_wr_idx", wr_idx, 0);
        chk("p2_wr_val", wr_val, 2);
        p2_req = 1'b0; occ = 9'h011;
        step();
        chk("p2_chk_start", chk_start, 1);
        chk_done = 1'b1; chk_result = 2'b00;
        step();
        chk_done = 1'b0;
        chk("flip_to_p1", player, 0);

        // Rejects on P1's turn.
        p1_req = 1'b1; p1_move = 9'b000010000;
        step();
        chk("occ_nack", p1_nack, 1);
        chk("occ_no_ack", p1_ack, 0);
        chk("occ_no_write", wr_en, 0);
        p1_req = 1'b0;
        step();
        chk("occ_stay_wait", busy, 0);
        chk("nack_one_cycle", p1_nack, 0);

        p1_req = 1'b1; p1_move = 9'b000000011;
        step();
        chk("twohot_nack", p1_nack, 1);
        chk("twohot_no_write", wr_en, 0);
        p1_req = 1'b0;
        step();

        p2_req = 1'b1; p2_move = 9'b100000000;
        step();
        chk("wrong_turn_nack", p2_nack, 1);
        chk("wrong_turn_no_ack", p2_ack, 0);
        chk("wrong_turn_no_write", wr_en, 0);
        p2_req = 1'b0;
        step();

        // Held request: one nack until the request drops for a cycle.
        p1_req = 1'b1; p1_move = 9'b000000000;
        step();
        chk("held_nack1", p1_nack, 1);
        step();
        chk("held_quiet1", p1_nack, 0);
        step();
        chk("held_quiet2", p1_nack, 0);
        p1_req = 1'b0;
        step();
        p1_req = 1'b1;
        step();
        chk("rearmed_nack", p1_nack, 1);
        p1_req = 1'b0;
        step();

        // Stray chk_done in WAIT is ignored.
        chk_done = 1'b1; chk_result = 2'b10;
        step();
        chk_done = 1'b0;
        chk("stray_done_winner", winner, 0);
        chk("stray_done_busy", busy, 0);
        chk("stray_done_player", player, 0);

        // Simultaneous requests on P1's turn.
        p1_req = 1'b1; p1_move = 9'b000000100;
        p2_req = 1'b1; p2_move = 9'b000001000;
        step();
        chk("sim_p1_ack", p1_ack, 1);
        chk("sim_p2_nack", p2_nack, 1);
        chk("sim_p2_no_ack", p2_ack, 0);
        chk("sim_wr_idx", wr_idx, 2);
        chk("sim_wr_val", wr_val, 1);
        p1_req = 1'b0; p2_req = 1'b0; occ = 9'h015;
        step();
        // P2 request raised during CHECK must wait for WAIT.
        p2_req = 1'b1; p2_move = 9'b000001000;
        step();
        step();
        chk("pending_no_ack", p2_ack, 0);
        chk("pending_no_nack", p2_nack, 0);
        chk_done = 1'b1; chk_result = 2'b00;
        step();
        chk_done = 1'b0;
        chk("pending_player", player, 1);
        chk("pending_wait", busy, 0);
        chk("pending_still_no_ack", p2_ack, 0);
        step();
        chk("pending_ack", p2_ack, 1);
        chk("pending_wr_idx", wr_idx, 3);
        chk("pending_wr_val", wr_val, 2);
        p2_req = 1'b0; occ = 9'h01D;
        step();
        chk("win_chk_start", chk_start, 1);

        // Win by P2, hold 180 frames, then clear.
        chk_done = 1'b1; chk_result = 2'b10;
        step();
        chk_done = 1'b0;
        chk("win_winner", winner, 2);
        chk("win_busy", busy, 1);
        cnt = 0;
        while (!wr_en && cnt < 1000) begin
            step();
            cnt++;
        end
        chk("hold_len_in_window", (cnt >= 718 && cnt <= 721), 1);
        chk("hold_winner_kept", winner, 2);
        chk("hold_clr_idx0", wr_idx, 0);
        chk("hold_clr_val", wr_val, 0);
        for (int i = 1; i < 9; i++) begin
            step();
            chk("hold_clr_idx", wr_idx, i);
        end
        step();
        chk("newgame_player", player, 0);
        chk("newgame_winner", winner, 0);
        chk("newgame_busy", busy, 0);

        // Reset while waiting in CHECK; a late chk_done must be ignored.
        occ = 9'd0;
        p1_req = 1'b1; p1_move = 9'b100000000;
        step();
        chk("rstchk_ack", p1_ack, 1);
        chk("rstchk_wr_idx", wr_idx, 8);
        p1_req = 1'b0;
        step();
        chk("rstchk_start", chk_start, 1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstchk_busy", busy, 1);
        chk("rstchk_wr_en", wr_en, 0);
        chk_done = 1'b1; chk_result = 2'b01;
        step();
        chk_done = 1'b0;
        chk("rstchk_clr_en", wr_en, 1);
        chk("rstchk_clr_idx0", wr_idx, 0);
        chk("rstchk_winner", winner, 0);
        for (int i = 1; i < 9; i++) begin
            step();
            chk("rstchk_clr_idx", wr_idx, i);
        end
        step();
        chk("rstchk_wait", busy, 0);
        chk("rstchk_final_winner", winner, 0);
        chk("rstchk_final_player", player, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
